// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_pkg
//  Purpose  : Shared types and helpers for the single-port-RAM FWFT FIFO
//             controller.
//             - mem_op_e : operation placed on the single RAM port in a cycle
//             - ptr_inc  : pointer increment with explicit wrap at depth-1,
//                          so that depths which are not a power of two work
//  Revision : 1.0  initial release
// ============================================================================
package sync_fifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_WR   = 2'd1,
    OP_RD   = 2'd2
  } mem_op_e;

  // The caller casts the result back to its own pointer width.
  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr,
                                          input logic [31:0] depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage : sync_fifo_pkg
`default_nettype wire

// File: rtl/fwft_out_buf.sv
`default_nettype none
// ============================================================================
//  Module   : fwft_out_buf
//  Purpose  : Two-entry ordered output buffer. Slot 0 is always the head
//             word, so head_data is a plain register output.
//  Ports    : clk, rst       - clock, synchronous active-high reset
//             push/push_data - append one word (at most one source per cycle)
//             pop            - remove the head word (ignored when empty)
//             head_data      - current head word
//             count          - number of words held (0..2)
//  Revision : 1.0  initial release
// ============================================================================
module fwft_out_buf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] r_slot0;
  logic [DATA_WIDTH-1:0] r_slot1;
  logic [1:0]            r_count;
  logic                  w_pop;

  assign w_pop     = pop && (r_count != 2'd0);
  assign head_data = r_slot0;
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 2'd0;
    end else begin
      r_count <= r_count + {1'b0, push} - {1'b0, w_pop};
    end
  end

  // Data slots carry no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      // With one word held, an incoming word becomes the new head directly;
      // with two held, the second word shifts forward.
      r_slot0 <= (r_count == 2'd1) ? push_data : r_slot1;
      if (push && (r_count == 2'd2)) begin
        r_slot1 <= push_data;
      end
    end else if (push) begin
      if (r_count == 2'd0) begin
        r_slot0 <= push_data;
      end else begin
        r_slot1 <= push_data;
      end
    end
  end

endmodule : fwft_out_buf
`default_nettype wire

// File: rtl/sync_fifo_spram_fwft_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_spram_fwft_ctrl
//  Purpose  : First-word-fall-through FIFO controller driving one single-port
//             RAM. Reads (prefetch into a 2-entry output buffer) take the RAM
//             port ahead of writes; pushes into an otherwise empty pipeline
//             bypass the RAM straight into the output buffer.
//             Capacity is FIFO_DEPTH + 2 words.
//  Ports    : clk, rst                       - clock, sync active-high reset
//             in_valid/in_ready/in_data      - push interface
//             out_valid/out_ready/out_data   - FWFT pop interface
//             level                          - total words held
//             mem_cs/mem_we/mem_addr/mem_wdata/mem_rdata - RAM port
//             err_overflow/err_underflow     - sticky error flags, present
//                                              only with SYNC_FIFO_ERR_EN
//  Options  : `define SYNC_FIFO_ERR_EN to add the sticky error flags.
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo_spram_fwft_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int LVL_WIDTH  = $clog2(FIFO_DEPTH + 3)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [LVL_WIDTH-1:0]  level,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef SYNC_FIFO_ERR_EN
  ,
  output logic                  err_overflow,
  output logic                  err_underflow
`endif
);

  localparam logic [LVL_WIDTH-1:0] c_ram_depth = LVL_WIDTH'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [LVL_WIDTH-1:0]  r_ram_cnt;
  logic                  r_rd_pend;

  logic [1:0]            w_ob_cnt;
  logic [2:0]            w_ob_after_pop;
  logic                  w_pop;
  logic                  w_rd_issue;
  logic                  w_bypass_ok;
  logic                  w_push;
  logic                  w_wr_ram;
  logic                  w_wr_bypass;
  logic                  w_ob_push;
  logic [DATA_WIDTH-1:0] w_ob_data;
  mem_op_e               w_op;

  assign out_valid = (w_ob_cnt != 2'd0);
  assign w_pop     = out_valid && out_ready;

  // Buffer occupancy once this cycle's pop is taken out (never negative,
  // since a pop requires a held word).
  assign w_ob_after_pop = {1'b0, w_ob_cnt} - {2'b00, w_pop};

  // Prefetch only when the landing word is guaranteed a free buffer slot,
  // counting the read already in flight.
  assign w_rd_issue  = (r_ram_cnt != '0) &&
                       ((w_ob_after_pop + {2'b00, r_rd_pend}) < 3'd2);

  // Bypass keeps ordering: only legal when nothing is queued in RAM or in
  // flight ahead of the incoming word.
  assign w_bypass_ok = (r_ram_cnt == '0) && !r_rd_pend &&
                       (w_ob_after_pop < 3'd2);

  // Reads own the RAM port, so a RAM write is refused on read cycles.
  assign in_ready    = !rst &&
                       (w_bypass_ok || ((r_ram_cnt < c_ram_depth) && !w_rd_issue));

  assign w_push      = in_valid && in_ready;
  assign w_wr_bypass = w_push && w_bypass_ok;
  assign w_wr_ram    = w_push && !w_bypass_ok;

  always_comb begin
    w_op = OP_IDLE;
    if (w_rd_issue) begin
      w_op = OP_RD;
    end else if (w_wr_ram) begin
      w_op = OP_WR;
    end
  end

  assign mem_cs    = (w_op != OP_IDLE);
  assign mem_we    = (w_op == OP_WR);
  assign mem_addr  = (w_op == OP_RD) ? r_rd_ptr : r_wr_ptr;
  assign mem_wdata = in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ram_cnt <= '0;
      r_rd_pend <= 1'b0;
    end else begin
      r_rd_pend <= (w_op == OP_RD);
      if (w_op == OP_RD) begin
        r_rd_ptr  <= ADDR_WIDTH'(ptr_inc(32'(r_rd_ptr), 32'(FIFO_DEPTH)));
        r_ram_cnt <= r_ram_cnt - LVL_WIDTH'(1);
      end else if (w_op == OP_WR) begin
        r_wr_ptr  <= ADDR_WIDTH'(ptr_inc(32'(r_wr_ptr), 32'(FIFO_DEPTH)));
        r_ram_cnt <= r_ram_cnt + LVL_WIDTH'(1);
      end
    end
  end

  // A landing read and a bypass write are mutually exclusive (bypass needs
  // no read in flight), so one mux feeds the buffer.
  assign w_ob_push = r_rd_pend || w_wr_bypass;
  assign w_ob_data = r_rd_pend ? mem_rdata : in_data;

  fwft_out_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (w_ob_push),
    .push_data (w_ob_data),
    .pop       (w_pop),
    .head_data (out_data),
    .count     (w_ob_cnt)
  );

  assign level = r_ram_cnt + LVL_WIDTH'(r_rd_pend) + LVL_WIDTH'(w_ob_cnt);

`ifdef SYNC_FIFO_ERR_EN
  logic r_err_ovf;
  logic r_err_unf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
    end else begin
      if (in_valid && !in_ready) begin
        r_err_ovf <= 1'b1;
      end
      if (out_ready && !out_valid) begin
        r_err_unf <= 1'b1;
      end
    end
  end

  assign err_overflow  = r_err_ovf;
  assign err_underflow = r_err_unf;
`endif

endmodule : sync_fifo_spram_fwft_ctrl
`default_nettype wire

// File: tb/tb_sync_fifo_spram_fwft_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_fifo_spram_fwft_ctrl
//  Purpose  : Self-checking bench for sync_fifo_spram_fwft_ctrl with
//             DATA_WIDTH=8, FIFO_DEPTH=4 and a behavioural single-port RAM.
//             A word-queue reference model is compared on every cycle;
//             directed sequences pin literal values. Error flags are checked
//             when SYNC_FIFO_ERR_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sync_fifo_spram_fwft_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int LW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [LW-1:0] level;
  logic          mem_cs;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
`ifdef SYNC_FIFO_ERR_EN
  logic          err_overflow;
  logic          err_underflow;
`endif

  sync_fifo_spram_fwft_ctrl #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef SYNC_FIFO_ERR_EN
    ,
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM: read data appears the cycle after access.
  logic [DW-1:0] ram [DEPTH];
  initial forever @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // All words held, oldest first; split into buffer / in-flight / RAM parts
  // by occupancy counts only.
  logic [DW-1:0] q[$];
  int m_ob = 0, m_pend = 0, m_ram = 0, m_wp = 0, m_rp = 0;
  bit m_ovf = 0, m_unf = 0;

  initial forever @(negedge clk) begin
    bit m_pop, m_rd, m_byp, m_inr, m_push, m_wr;
    logic [DW-1:0] dummy;
    if (rst) begin
      chk("in_ready_in_reset", int'(in_ready), 0);
      q.delete();
      m_ob = 0; m_pend = 0; m_ram = 0; m_wp = 0; m_rp = 0;
      m_ovf = 0; m_unf = 0;
    end else begin
      m_pop  = (m_ob > 0) && out_ready;
      m_rd   = (m_ram > 0) && ((m_ob + m_pend - int'(m_pop)) < 2);
      m_byp  = (m_ram == 0) && (m_pend == 0) && ((m_ob - int'(m_pop)) < 2);
      m_inr  = m_byp || ((m_ram < DEPTH) && !m_rd);
      m_push = in_valid && m_inr;
      m_wr   = m_push && !m_byp;

      chk("out_valid", int'(out_valid), int'(m_ob > 0));
      chk("level", int'(level), q.size());
      chk("in_ready", int'(in_ready), int'(m_inr));
      chk("mem_cs", int'(mem_cs), int'(m_rd || m_wr));
      chk("mem_we", int'(mem_we), int'(m_wr));
      if (m_ob > 0) chk("out_data", int'(out_data), int'(q[0]));
      if (m_rd) chk("mem_addr_rd", int'(mem_addr), m_rp);
      if (m_wr) begin
        chk("mem_addr_wr", int'(mem_addr), m_wp);
        chk("mem_wdata", int'(mem_wdata), int'(in_data));
      end
`ifdef SYNC_FIFO_ERR_EN
      chk("err_overflow", int'(err_overflow), int'(m_ovf));
      chk("err_underflow", int'(err_underflow), int'(m_unf));
      if (in_valid && !m_inr) m_ovf = 1;
      if (out_ready && !(m_ob > 0)) m_unf = 1;
`endif
      if (m_pop) dummy = q.pop_front();
      if (m_push) q.push_back(in_data);
      m_ob   = m_ob - int'(m_pop) + m_pend + int'(m_push && m_byp);
      m_pend = int'(m_rd);
      m_ram  = m_ram - int'(m_rd) + int'(m_wr);
      if (m_rd) m_rp = (m_rp + 1) % DEPTH;
      if (m_wr) m_wp = (m_wp + 1) % DEPTH;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit rs, input bit v, input logic [DW-1:0] d, input bit r);
    @(posedge clk);
    #1;
    rst = rs; in_valid = v; in_data = d; out_ready = r;
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    int acc, pops, pushes, pin, pout;

    // 1: single push after reset takes the bypass path
    do_reset();
    chk("t1_rst_out_valid", int'(out_valid), 0);
    chk("t1_rst_level", int'(level), 0);
    chk("t1_rst_mem_cs", int'(mem_cs), 0);
    step(1'b0, 1'b1, 8'hA5, 1'b0);
    chk("t1_push_mem_cs", int'(mem_cs), 0);
    chk("t1_push_ready", int'(in_ready), 1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("t1_out_valid", int'(out_valid), 1);
    chk("t1_out_data", int'(out_data), 'hA5);
    chk("t1_level", int'(level), 1);
    chk("t1_mem_cs", int'(mem_cs), 0);

    // 2: fill with no pops -> 6 accepted
    do_reset();
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b0);
      if (in_ready) acc++;
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("t2_accepted", acc, 6);
    chk("t2_level", int'(level), 6);
    chk("t2_in_ready", int'(in_ready), 0);

    // 3: drain continuously
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      chk("t3_out_valid", int'(out_valid), 1);
      chk("t3_out_data", int'(out_data), i);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("t3_empty_valid", int'(out_valid), 0);
    chk("t3_empty_level", int'(level), 0);

    // 4: steady push+pop with words in RAM
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h20 + i), 1'b0);
    pushes = 4; pops = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'(8'h30 + i), 1'b1);
      chk("t4_ready_vs_read", int'(in_ready), int'(!(mem_cs && !mem_we)));
      if (in_ready) pushes++;
      if (out_valid) pops++;
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      if (out_valid) pops++;
    end
    chk("t4_pop_count", pops, pushes);
    chk("t4_level_end", int'(level), 0);

    // 5: reset with a read in flight
    do_reset();
    step(1'b0, 1'b1, 8'h40, 1'b0);
    step(1'b0, 1'b1, 8'h41, 1'b0);
    step(1'b0, 1'b1, 8'h42, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t5_read_issue", int'(mem_cs && !mem_we), 1);
    do_reset();
    chk("t5_rst_valid", int'(out_valid), 0);
    chk("t5_rst_level", int'(level), 0);
    step(1'b0, 1'b1, 8'h11, 1'b0);
    chk("t5_bypass_cs", int'(mem_cs), 0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("t5_out_valid", int'(out_valid), 1);
    chk("t5_out_data", int'(out_data), 'h11);
    chk("t5_level", int'(level), 1);

`ifdef SYNC_FIFO_ERR_EN
    // 6: sticky error flags
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'(8'h50 + i), 1'b0);
    step(1'b0, 1'b1, 8'h99, 1'b0);
    chk("t6_full_ready", int'(in_ready), 0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("t6_ovf", int'(err_overflow), 1);
    chk("t6_level", int'(level), 6);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      chk("t6_drain_data", int'(out_data), 'h50 + i);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t6_empty", int'(out_valid), 0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("t6_unf", int'(err_underflow), 1);
    chk("t6_ovf_held", int'(err_overflow), 1);
`endif

    // Random traffic with changing push/pop densities and rare resets.
    do_reset();
    for (int blk = 0; blk < 8; blk++) begin
      pin  = (blk % 3 == 0) ? 25 : (blk % 3 == 1) ? 90 : 55;
      pout = (blk % 4 == 0) ? 85 : (blk % 4 == 1) ? 20 : (blk % 4 == 2) ? 50 : 95;
      for (int c = 0; c < 400; c++) begin
        step(($urandom_range(0, 299) == 0),
             ($urandom_range(0, 99) < pin),
             8'($urandom),
             ($urandom_range(0, 99) < pout));
      end
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_sync_fifo_spram_fwft_ctrl
`default_nettype wire
